// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one ALU between two requesters
package alu_arbiter_pkg;
  typedef logic [31:0] data_t;
  typedef enum logic [2:0] {
    ALU_OP_ADD, ALU_OP_SUB, ALU_OP_AND, ALU_OP_OR,
    ALU_OP_XOR, ALU_OP_SLT, ALU_OP_SLL, ALU_OP_SRL
  } alu_op_t;
endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  alu_op_t     req0_op,
  input  alu_op_t     req1_op,
  input  data_t       req0_a,
  input  data_t       req1_a,
  input  data_t       req0_b,
  input  data_t       req1_b,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output data_t       resp0_data,
  output data_t       resp1_data,
  output alu_op_t     alu_operator,
  output data_t       alu_operand1,
  output data_t       alu_operand2,
  input  data_t       alu_out,
  output logic [31:0] issue_count
);
  logic s_valid, s_id, ptr;
  alu_op_t s_op;
  data_t s_a, s_b;
  logic [1:0] pop, hit, elig;
  assign pop = resp_valid & resp_ready;
  assign hit = {s_valid & s_id, s_valid & ~s_id};
  assign elig = rst ? 2'b00 : req_valid & ~hit & (~resp_valid | pop);
  assign req_ready = &elig ? (ptr ? 2'b10 : 2'b01) : elig;
  assign alu_operator = s_valid ? s_op : ALU_OP_ADD;
  assign alu_operand1 = s_valid ? s_a : '0;
  assign alu_operand2 = s_valid ? s_b : '0;
  always_ff @(posedge clk)
    if (rst) begin
      s_valid <= 1'b0;
      s_id <= 1'b0;
      s_op <= ALU_OP_ADD;
      s_a <= '0;
      s_b <= '0;
      ptr <= 1'b0;
      resp_valid <= 2'b00;
      resp0_data <= '0;
      resp1_data <= '0;
      issue_count <= '0;
    end else begin
      s_valid <= |req_ready;
      s_id <= req_ready[1];
      s_op <= req_ready[1] ? req1_op : req0_op;
      s_a <= req_ready[1] ? req1_a : req0_a;
      s_b <= req_ready[1] ? req1_b : req0_b;
      if (|req_ready) ptr <= req_ready[0];
      issue_count <= issue_count + {31'd0, |req_ready};
      resp_valid <= hit | (resp_valid & ~pop);
      if (hit[0]) resp0_data <= alu_out;
      if (hit[1]) resp1_data <= alu_out;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Ports SHALL be as follows, clock and reset first:
  clk  in  1  clock; all state updates on rising edge
  rst  in  1  synchronous active-high reset
  req_valid  in  2  per-requester request valid (bit i = requester i)
  req_ready  out  2  per-requester accept; handshake when valid & ready in the same cycle
  req0_op, req1_op  in  alu_op_t  requested operation
  req0_a, req1_a  in  data_t  operand1
  req0_b, req1_b  in  data_t  operand2
  resp_valid  out  2  per-requester result valid
  resp_ready  in  2  per-requester result consume
  resp0_data, resp1_data  out  data_t  result
  alu_operator  out  alu_op_t  drives the shared alu instance
  alu_operand1, alu_operand2  out  data_t  drive the shared alu instance
  alu_out  in  data_t  combinational result from the shared alu instance
  issue_count  out  32  number of accepted requests, modulo 2^32

Function
REQ-003 The block SHALL contain one issue stage: s_valid, s_id (1 bit), s_op, s_a, s_b.
REQ-004 alu_operator/alu_operand1/alu_operand2 SHALL be driven from s_op/s_a/s_b when s_valid=1, else ALU_OP_ADD/0/0.
REQ-005 Each requester SHALL have one response slot holding resp_valid[i] and resp_data.
REQ-006 A response pop SHALL occur when resp_valid[i] & resp_ready[i]; a pop clears resp_valid[i] at the next edge unless refilled in the same cycle.
REQ-007 Requester i SHALL be eligible when req_valid[i]=1, !(s_valid & s_id==i), and resp slot i is empty or popped this cycle.
REQ-008 At most one request SHALL be granted per cycle; req_ready SHALL be one-hot or zero and depend combinationally on req_valid, resp_ready and state.
REQ-009 Arbitration SHALL be round-robin: a 1-bit pointer names the priority requester; if both are eligible, the pointer's requester wins; if only one is eligible, it wins regardless of the pointer.
REQ-010 After a grant to requester i, the pointer SHALL become 1-i; without a grant, the pointer SHALL hold.
REQ-011 On a grant, the stage SHALL load s_valid=1, s_id=i, and the op and operands of requester i; with no grant, s_valid SHALL be 0 at the next edge.
REQ-012 When s_valid=1, at the same edge, resp_data[s_id] SHALL load alu_out and resp_valid[s_id] SHALL become 1.
REQ-013 Latency SHALL be 2 cycles: a request accepted at edge N has resp_valid high after edge N+2 and stays high until popped.
REQ-014 Peak throughput SHALL be one accept per cycle when requesters alternate; a single requester SHALL get at most one accept per 2 cycles.
REQ-015 Results SHALL be in order per requester; each requester has at most one request outstanding (stage or slot).
REQ-016 issue_count SHALL increment by 1 on each accepted handshake and wrap 0xFFFFFFFF -> 0.
REQ-017 Operand width and arithmetic SHALL be those of data_t/alu_op_t; the block SHALL not modify alu_out.

Reset
REQ-018 While rst=1 at an edge: s_valid=0, resp_valid=2'b00, pointer=0, issue_count=0, resp_data=0.
REQ-019 Reset mid-operation SHALL discard the in-flight stage and unconsumed results; no resp_valid may assert in the cycle after reset deasserts.
REQ-020 req_ready SHALL be 2'b00 while rst=1.

Verification
REQ-021 Single op: req0 ADD a=5 b=7, resp_ready=1 -> req_ready=01 at cycle 0; resp_valid[0]=1 with resp0_data=12 at cycle 2; issue_count=1.
REQ-022 Contention: both valid continuously (req0 SUB 10,3; req1 XOR 0xF0,0xFF) after reset -> grants 0,1,0,1...; resp0=7, resp1=0x0F; one accept per cycle.
REQ-023 Backpressure: resp_ready[0]=0 with req0 valid -> after the first result, req_ready[0]=0 indefinitely; resp_ready[0]=1 -> pop and new accept in the same cycle.
REQ-024 Idle drive: no requests -> alu_operator=ALU_OP_ADD and operands 0; resp_valid stays 00.
REQ-025 Reset mid-flight: assert rst one cycle after accepting req1 SLT -> resp_valid stays 00 and issue_count=0 after reset; the next grant with both valid goes to requester 0.
REQ-026 Wrap: force issue_count to 0xFFFFFFFF, accept one -> issue_count=0.
